mem_arbiter: RTL

Two-requester arbiter that shares one single-port unified memory between the `riscv` core's instruction-fetch path and its load/store path. It accepts one transaction at a time from either requester, drives the memory with registered command signals, and waits for the memory's `m_ack`. It returns a one-cycle `done` pulse with read data, or an error pulse on timeout. Round-robin on contention keeps fetch from starving under back-to-back loads/stores.

---
 rtl/mem_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port memory between the instruction-fetch requester (if_*)
//   and the load/store requester (d_*). One transaction is in flight at a time.
//   The command is registered onto m_* at grant and held until the memory acks
//   or the transaction times out. The winner then sees a one-cycle done pulse
//   carrying err and rdata. When both requesters are pending, the grant
//   alternates between them.
//
//   Handshake rules, both sides:
//     requester side : req and its fields are held by the requester until the
//                      one-cycle done pulse. done/err/rdata are meaningful
//                      only in that cycle.
//     memory side    : m_req stays high with a stable command until the cycle
//                      in which m_ack is sampled high (or timeout). m_ack
//                      outside that window is ignored.
//
//   Parameters : AW address width, DW data width (multiple of 8),
//                TIMEOUT max m_req cycles without m_ack (0 = never abort)
//   Ports      : clk, reset (sync, active high)
//                if_req/if_addr -> if_done/if_err/if_rdata     fetch requester
//                d_req/d_we/d_addr/d_wdata/d_be
//                  -> d_done/d_err/d_rdata                     data requester
//                m_req/m_we/m_addr/m_wdata/m_be, m_ack/m_rdata memory port
//                m_owner   current/last owner (0 fetch, 1 data)
//                dbg_state FSM state: 0 IDLE, 1 REQ, 2 RESP
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_done,
    output logic            if_err,
    output logic [DW-1:0]   if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic            d_done,
    output logic            d_err,
    output logic [DW-1:0]   d_rdata,
    output logic            m_req,
    output logic            m_we,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    output logic [DW/8-1:0] m_be,
    input  logic            m_ack,
    input  logic [DW-1:0]   m_rdata,
    output logic            m_owner,
    output logic [1:0]      dbg_state
);

    localparam int BW = DW / 8;
    // Counter indexes REQ cycles 0..TIMEOUT-1.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_n;
    logic            last_owner;
    logic [CW-1:0]   tmo_cnt;
    logic            rsp_err;
    logic [DW-1:0]   rsp_data;

    logic            grant;
    logic            grant_owner;
    logic            tmo_hit;

    // Next state and grant decision.
    always_comb begin
        state_n     = state;
        grant       = 1'b0;
        grant_owner = last_owner;
        tmo_hit     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (if_req || d_req) begin
                    grant       = 1'b1;
                    // Tie goes to whoever did not win last; otherwise the only one asking.
                    grant_owner = (if_req && d_req) ? ~last_owner : d_req;
                    state_n     = S_REQ;
                end
            end
            S_REQ: begin
                // An ack in the last allowed cycle still wins over the timeout.
                tmo_hit = (TIMEOUT != 0) && !m_ack && (tmo_cnt == TMO_LAST);
                if (m_ack || tmo_hit) begin
                    state_n = S_RESP;
                end
            end
            S_RESP: begin
                // The finishing owner's req is still high this cycle, so only
                // the other requester may be granted straight away.
                if (last_owner ? if_req : d_req) begin
                    grant       = 1'b1;
                    grant_owner = ~last_owner;
                    state_n     = S_REQ;
                end else begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Memory command and response capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_be       <= '0;
            last_owner <= 1'b0;
            tmo_cnt    <= '0;
            rsp_err    <= 1'b0;
            rsp_data   <= '0;
        end else if (grant) begin
            m_req      <= 1'b1;
            last_owner <= grant_owner;
            tmo_cnt    <= '0;
            if (grant_owner) begin
                m_we    <= d_we;
                m_addr  <= d_addr;
                m_wdata <= d_wdata;
                m_be    <= d_we ? d_be : {BW{1'b1}};
            end else begin
                m_we    <= 1'b0;
                m_addr  <= if_addr;
                m_wdata <= '0;
                m_be    <= {BW{1'b1}};
            end
        end else if (state == S_REQ) begin
            if (m_ack) begin
                m_req    <= 1'b0;
                rsp_err  <= 1'b0;
                // Stores report zero data regardless of what the memory drives.
                rsp_data <= m_we ? '0 : m_rdata;
            end else if (tmo_hit) begin
                m_req    <= 1'b0;
                rsp_err  <= 1'b1;
                rsp_data <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

    // Responses are decoded from registered state only.
    assign if_done   = (state == S_RESP) && !last_owner;
    assign d_done    = (state == S_RESP) && last_owner;
    assign if_err    = if_done && rsp_err;
    assign d_err     = d_done && rsp_err;
    assign if_rdata  = if_done ? rsp_data : '0;
    assign d_rdata   = d_done ? rsp_data : '0;
    assign m_owner   = last_owner;
    assign dbg_state = state;

endmodule
